// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan driver.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  // Digit slot currently being scanned; SCANk drives digit k+1.
  typedef enum logic [1:0] {
    SCAN0 = 2'd0,
    SCAN1 = 2'd1,
    SCAN2 = 2'd2,
    SCAN3 = 2'd3
  } scan_state_e;

  function automatic scan_state_e next_scan(input scan_state_e s);
    scan_state_e n;
    case (s)
      SCAN0:   n = SCAN1;
      SCAN1:   n = SCAN2;
      SCAN2:   n = SCAN3;
      default: n = SCAN0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD to active-high 7-segment decoder; codes above 9 show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Pure lookup of the digit glyph.
  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit 7-segment driver: per-frame digit snapshot,
// leading-zero blanking, dash for non-BCD codes, anode guard interval.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned COMMON_ANODE = 1,
  parameter int unsigned LZ_BLANK     = 1
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic [3:0] iDigit1,
  input  logic [3:0] iDigit2,
  input  logic [3:0] iDigit3,
  input  logic [3:0] iDigit4,
  output logic [3:0] oAn,
  output logic [6:0] oSeg,
  output logic       oFrame
);

  localparam int unsigned     CNT_W     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);
  localparam logic [3:0]       AN_OFF    = (COMMON_ANODE != 0) ? 4'b1111 : 4'b0000;
  localparam logic [6:0]       SEGS_OFF  = (COMMON_ANODE != 0) ? ~SEG_OFF : SEG_OFF;

  logic [CNT_W-1:0]                cnt_q, cnt_d;
  scan_state_e                     idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]      snap_q, snap_d;
  logic                            load_pending_q;
  logic [3:0]                      an_q, an_d;
  logic [6:0]                      seg_q, seg_d;
  logic                            frame_q, frame_d;

  logic                            tick;
  logic                            load;
  logic [NUM_DIGITS-1:0]           blank;
  logic [3:0]                      digit;
  logic [6:0]                      seg_raw;
  logic                            lit;
  logic [3:0]                      an_act;
  logic [6:0]                      seg_act;

  // Outputs are derived from next-state cnt/idx/snapshot so the registered
  // outputs line up with the registered counters without a pipeline stage.
  always_comb begin
    tick   = (cnt_q == CNT_MAX);
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    idx_d  = tick ? next_scan(idx_q) : idx_q;
    load   = load_pending_q || (tick && (idx_q == SCAN3));
    snap_d = load ? {iDigit4, iDigit3, iDigit2, iDigit1} : snap_q;

    blank    = '0;
    blank[3] = (LZ_BLANK != 0) && (snap_d[3] == 4'd0);
    blank[2] = blank[3] && (snap_d[2] == 4'd0);
    blank[1] = blank[2] && (snap_d[1] == 4'd0);

    digit   = snap_d[idx_d];
    lit     = (cnt_d >= BLANK_LIM) && !blank[idx_d];
    an_act  = lit ? (4'b0001 << idx_d) : 4'b0000;
    seg_act = lit ? seg_raw : SEG_OFF;

    an_d    = (COMMON_ANODE != 0) ? ~an_act : an_act;
    seg_d   = (COMMON_ANODE != 0) ? ~seg_act : seg_act;
    frame_d = load;
  end

  bcd_to_seg7 u_dec (
    .bcd_i (digit),
    .seg_o (seg_raw)
  );

  // Scan state, snapshot and registered display outputs.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      cnt_q          <= '0;
      idx_q          <= SCAN0;
      snap_q         <= '0;
      load_pending_q <= 1'b1;
      an_q           <= AN_OFF;
      seg_q          <= SEGS_OFF;
      frame_q        <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      snap_q         <= snap_d;
      load_pending_q <= 1'b0;
      an_q           <= an_d;
      seg_q          <= seg_d;
      frame_q        <= frame_d;
    end
  end

  assign oAn    = an_q;
  assign oSeg   = seg_q;
  assign oFrame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4, BLANK_CYCLES=1,
// common-anode polarity and leading-zero blanking.
module tb_seg7_scan_driver;

  logic       iclk = 1'b0;
  logic       irst;
  logic [3:0] iDigit1, iDigit2, iDigit3, iDigit4;
  logic [3:0] oAn;
  logic [6:0] oSeg;
  logic       oFrame;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned k      = 0;

  seg7_scan_driver #(
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1),
    .COMMON_ANODE (1),
    .LZ_BLANK     (1)
  ) dut (
    .iclk    (iclk),
    .irst    (irst),
    .iDigit1 (iDigit1),
    .iDigit2 (iDigit2),
    .iDigit3 (iDigit3),
    .iDigit4 (iDigit4),
    .oAn     (oAn),
    .oSeg    (oSeg),
    .oFrame  (oFrame)
  );

  always #5 iclk = ~iclk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h (k=%0d)", tag, obs, exp, k);
  endtask

  // One clock edge, sampled 1 time unit later.
  task automatic step();
    @(posedge iclk);
    #1;
    k++;
  endtask

  task automatic run_to(input int unsigned t);
    while (k < t) step();
  endtask

  task automatic set_digits(input logic [3:0] d4, input logic [3:0] d3,
                            input logic [3:0] d2, input logic [3:0] d1);
    iDigit4 = d4;
    iDigit3 = d3;
    iDigit2 = d2;
    iDigit1 = d1;
  endtask

  logic [3:0] an_tab  [4];
  logic [6:0] seg1234 [4];
  int unsigned cnt, slot;

  initial begin
    an_tab  = '{4'hE, 4'hD, 4'hB, 4'h7};
    seg1234 = '{7'h19, 7'h30, 7'h24, 7'h79};

    // Reset held
    irst = 1'b1;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    #22;
    check("rst_an", oAn, 4'hF);
    check("rst_seg", oSeg, 7'h7F);
    check("rst_frame", oFrame, 1'b0);

    // Release and first snapshot
    @(posedge iclk);
    #1;
    irst = 1'b0;
    k = 0;
    step();
    check("first_frame", oFrame, 1'b1);
    check("first_an", oAn, 4'hE);
    check("first_seg", oSeg, 7'h19);

    // Full frame of 1234
    for (int unsigned i = 2; i <= 16; i++) begin
      step();
      cnt  = k % 4;
      slot = (k / 4) % 4;
      check("f1234_an", oAn, (cnt == 0) ? 4'hF : an_tab[slot]);
      check("f1234_seg", oSeg, (cnt == 0) ? 7'h7F : seg1234[slot]);
      check("f1234_frame", oFrame, (k == 16) ? 1'b1 : 1'b0);
    end
    step();
    check("rep_frame", oFrame, 1'b0);
    check("rep_an", oAn, 4'hE);
    check("rep_seg", oSeg, 7'h19);

    // Tearing: change to 5678 during slot1
    run_to(21);
    set_digits(4'd5, 4'd6, 4'd7, 4'd8);
    check("tear_s1_an", oAn, 4'hD);
    check("tear_s1_seg", oSeg, 7'h30);
    run_to(25);
    check("tear_s2_seg", oSeg, 7'h24);
    run_to(29);
    check("tear_s3_an", oAn, 4'h7);
    check("tear_s3_seg", oSeg, 7'h79);
    run_to(32);
    check("tear_frame", oFrame, 1'b1);
    check("tear_guard_an", oAn, 4'hF);
    run_to(33);
    check("new_s0_an", oAn, 4'hE);
    check("new_s0_seg", oSeg, 7'h00);
    run_to(45);
    check("new_s3_an", oAn, 4'h7);
    check("new_s3_seg", oSeg, 7'h12);

    // Leading zeros: 0007
    set_digits(4'd0, 4'd0, 4'd0, 4'd7);
    run_to(48);
    check("lz7_frame", oFrame, 1'b1);
    for (int unsigned i = 49; i <= 63; i++) begin
      step();
      cnt  = k % 4;
      slot = (k / 4) % 4;
      check("lz7_an", oAn, (cnt != 0 && slot == 0) ? 4'hE : 4'hF);
      check("lz7_seg", oSeg, (cnt != 0 && slot == 0) ? 7'h78 : 7'h7F);
    end

    // Leading zeros: 0000 keeps units digit
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    run_to(65);
    check("lz0_an", oAn, 4'hE);
    check("lz0_seg", oSeg, 7'h40);
    run_to(69);
    check("lz0_s1_an", oAn, 4'hF);
    check("lz0_s1_seg", oSeg, 7'h7F);

    // Non-BCD tens digit
    set_digits(4'd0, 4'd0, 4'hA, 4'd5);
    run_to(81);
    check("nb_s0_an", oAn, 4'hE);
    check("nb_s0_seg", oSeg, 7'h12);
    run_to(85);
    check("nb_s1_an", oAn, 4'hD);
    check("nb_s1_seg", oSeg, 7'h3F);
    run_to(89);
    check("nb_s2_an", oAn, 4'hF);
    run_to(93);
    check("nb_s3_an", oAn, 4'hF);

    // Async reset mid-slot2
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    run_to(105);
    check("pre_rst_an", oAn, 4'hB);
    check("pre_rst_seg", oSeg, 7'h24);
    #2;
    irst = 1'b1;
    #1;
    check("async_an", oAn, 4'hF);
    check("async_seg", oSeg, 7'h7F);
    check("async_frame", oFrame, 1'b0);
    @(posedge iclk);
    #1;
    set_digits(4'd5, 4'd6, 4'd7, 4'd8);
    check("held_an", oAn, 4'hF);
    irst = 1'b0;
    k = 0;
    step();
    check("rel_frame", oFrame, 1'b1);
    check("rel_an", oAn, 4'hE);
    check("rel_seg", oSeg, 7'h00);
    run_to(4);
    check("rel_s1_guard", oAn, 4'hF);
    check("rel_s1_frame", oFrame, 1'b0);
    run_to(5);
    check("rel_s1_an", oAn, 4'hD);
    check("rel_s1_seg", oSeg, 7'h78);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
